rr_blocking_relay: RTL and testbench

//  Parametrised successor of the single-channel blocking-in/master-out relay. It polls NUM_CH

---
 rtl/rr_blocking_relay_if.sv | 33 +++
 rtl/rr_blocking_relay.sv | 112 +++++++++++
 tb/tb_rr_blocking_relay.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rr_blocking_relay_if.sv
// Relay handshake bundle: blocking inputs in,
// tagged master output out.
interface rr_blocking_relay_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32
);
  localparam int CH_W = $clog2(NUM_CH);

  logic [NUM_CH*DATA_W-1:0] b_in;
  logic [NUM_CH-1:0]        b_in_sync;
  logic [NUM_CH-1:0]        b_in_notify;
  logic [DATA_W-1:0]        m_out;
  logic [CH_W-1:0]          m_out_ch;
  logic                     m_out_notify;

  modport master (
    output b_in,
    output b_in_sync,
    input  b_in_notify,
    input  m_out,
    input  m_out_ch,
    input  m_out_notify
  );

  modport slave (
    input  b_in,
    input  b_in_sync,
    output b_in_notify,
    output m_out,
    output m_out_ch,
    output m_out_notify
  );
endinterface

// File: rtl/rr_blocking_relay.sv
// Round-robin blocking-input relay with FIFO,
// optional per-channel running sum, throttled output.
module rr_blocking_relay #(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int MODE    = 0,
  parameter int OUT_GAP = 0
) (
  input  logic               clk,
  input  logic               rst,
  rr_blocking_relay_if.slave bus
);
  localparam int CH_W = $clog2(NUM_CH);
  localparam int AW   = $clog2(DEPTH);
  localparam int GW   =
    (OUT_GAP > 0) ? $clog2(OUT_GAP + 1) : 1;

  localparam logic [CH_W-1:0] LAST_CH =
    CH_W'(NUM_CH - 1);
  localparam logic [AW:0]     FULL = (AW+1)'(DEPTH);
  localparam logic [GW-1:0]   GAP  = GW'(OUT_GAP);

  typedef struct packed {
    logic [CH_W-1:0]   ch;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            mem [DEPTH];
  logic [DATA_W-1:0] sum [NUM_CH];
  logic [CH_W-1:0]   ptr;
  logic [CH_W-1:0]   ptr_next;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic [AW:0]       count_next;
  logic [GW-1:0]     gap;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] word;
  logic              push;
  logic              pop;

  // Notify is one-hot at ptr, so only the polled
  // channel can transfer in a given cycle.
  always_comb begin
    ptr_next = (ptr == LAST_CH) ? '0 : ptr + CH_W'(1);
    din      = bus.b_in[ptr*DATA_W +: DATA_W];
    push     = bus.b_in_sync[ptr] & bus.b_in_notify[ptr];
    pop      = (count != '0) && (gap == '0);
    word     = (MODE == 1) ? sum[ptr] + din : din;
    count_next = count
               + {{AW{1'b0}}, push}
               - {{AW{1'b0}}, pop};
  end

  // Poll pointer, occupancy, gap timer and notify.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr             <= '0;
      count           <= '0;
      gap             <= '0;
      bus.b_in_notify <= NUM_CH'(1);
    end else begin
      ptr   <= ptr_next;
      count <= count_next;
      if (count_next < FULL)
        bus.b_in_notify <= NUM_CH'(1) << ptr_next;
      else
        bus.b_in_notify <= '0;
      if (pop)
        gap <= GAP;
      else if (gap != '0)
        gap <= gap - GW'(1);
    end
  end

  // Write side: FIFO pointer and running sums.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      for (int i = 0; i < NUM_CH; i++)
        sum[i] <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + AW'(1);
      if (MODE == 1)
        sum[ptr] <= word;
    end
  end

  // Storage has no reset; occupancy guards reads.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= '{ch: ptr, data: word};
  end

  // Read side: registered output, held when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr           <= '0;
      bus.m_out        <= '0;
      bus.m_out_ch     <= '0;
      bus.m_out_notify <= 1'b0;
    end else begin
      bus.m_out_notify <= pop;
      if (pop) begin
        rd_ptr       <= rd_ptr + AW'(1);
        bus.m_out    <= mem[rd_ptr].data;
        bus.m_out_ch <= mem[rd_ptr].ch;
      end
    end
  end
endmodule

// File: tb/tb_rr_blocking_relay.sv
// Bench: four relay variants on shared stimulus,
// each with its own scoreboard.
module tb_rr_blocking_relay;
  localparam int NCH = 4;
  localparam int DW  = 32;
  localparam int NI  = 4;

  typedef struct packed {
    logic [1:0]    ch;
    logic [DW-1:0] d;
  } item_t;

  typedef struct {
    logic [3:0] sync;
    logic [3:0] nt;
    logic       mn;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NCH*DW-1:0]          b_in = '0;
  logic [NCH-1:0]             sync = '0;
  logic [NI-1:0]              win  = '0;
  logic [NI-1:0][NCH-1:0]     nt;
  logic [NI-1:0]              mn;
  logic [NI-1:0][DW-1:0]      mo;
  logic [NI-1:0][1:0]         mc;

  vec_t tv [9];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h",
               name, act, exp);
    end
  endtask

  // lane0 default, lane1 sum+gap, lane2 gap,
  // lane3 depth 2 + gap
  for (genvar g = 0; g < NI; g++) begin : lane
    rr_blocking_relay_if #(
      .NUM_CH(NCH), .DATA_W(DW)
    ) bus ();

    assign bus.b_in      = b_in;
    assign bus.b_in_sync = sync;
    assign nt[g] = bus.b_in_notify;
    assign mn[g] = bus.m_out_notify;
    assign mo[g] = bus.m_out;
    assign mc[g] = bus.m_out_ch;

    rr_blocking_relay #(
      .NUM_CH (NCH),
      .DATA_W (DW),
      .DEPTH  (g == 3 ? 2 : 4),
      .MODE   (g == 1 ? 1 : 0),
      .OUT_GAP(g == 0 ? 0 : 3)
    ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );

    item_t          q [$];
    logic [DW-1:0]  outs [$];
    logic [DW-1:0]  ms [NCH];
    logic [DW-1:0]  last_o;
    logic [NCH-1:0] prev_nt;
    int             last_p;
    int             np;
    int             pend;

    always @(negedge clk) begin
      item_t         e;
      logic [DW-1:0] d;
      if (!rst) begin
        q.delete();
        outs.delete();
        for (int c = 0; c < NCH; c++) ms[c] = '0;
        last_o = '0;
        prev_nt = '0;
      end else begin
        if (!win[g]) begin
          last_p = -1;
          np = 0;
        end
        if (mn[g]) begin
          if (q.size() == 0) begin
            chk("unexpected_out", mn[g], 1'b0);
          end else begin
            e = q.pop_front();
            chk("out_data", mo[g], e.d);
            chk("out_ch", mc[g], e.ch);
          end
          last_o = mo[g];
          outs.push_back(mo[g]);
          if (win[g]) begin
            if (last_p >= 0)
              chk("gap4", cyc - last_p, 4);
            chk("notify_after_pop", nt[g] != '0, 1);
            if (np > 0)
              chk("full_before_pop", prev_nt, 0);
            last_p = cyc;
            np++;
          end
        end else begin
          chk("hold", mo[g], last_o);
        end
        for (int c = 0; c < NCH; c++) begin
          if (sync[c] & nt[g][c]) begin
            d = b_in[c*DW +: DW];
            if (g == 1) begin
              ms[c] = ms[c] + d;
              d = ms[c];
            end
            e.ch = 2'(c);
            e.d = d;
            q.push_back(e);
          end
        end
        prev_nt = nt[g];
      end
      pend = q.size();
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold sync until lane inst notifies ch.
  task automatic send(input int inst,
                      input int ch,
                      input logic [DW-1:0] d);
    bit ok = 1'b0;
    b_in[ch*DW +: DW] = d;
    sync[ch] = 1'b1;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (nt[inst][ch]) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    sync[ch] = 1'b0;
    chk("send_accept", ok, 1'b1);
  endtask

  initial begin
    logic [NCH-1:0] upd;
    int n0;

    tv[0] = '{4'b0000, 4'b0001, 1'b0};
    tv[1] = '{4'b0100, 4'b0010, 1'b0};
    tv[2] = '{4'b0000, 4'b0100, 1'b0};
    tv[3] = '{4'b0000, 4'b1000, 1'b0};
    tv[4] = '{4'b0000, 4'b0001, 1'b0};
    tv[5] = '{4'b0010, 4'b0010, 1'b0};
    tv[6] = '{4'b0000, 4'b0100, 1'b0};
    tv[7] = '{4'b0000, 4'b1000, 1'b1};
    tv[8] = '{4'b0000, 4'b0001, 1'b0};

    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("rst_notify", nt[i], 4'b0001);
      chk("rst_mn", mn[i], 1'b0);
      chk("rst_mo", mo[i], 0);
      chk("rst_mc", mc[i], 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;

    for (int i = 0; i < 9; i++) begin
      sync = tv[i].sync;
      @(negedge clk);
      chk("tv_notify", nt[0], tv[i].nt);
      chk("tv_mn", mn[0], tv[i].mn);
      @(posedge clk);
      #1;
    end
    sync = '0;
    idle(6);

    send(0, 2, 32'h55);
    @(negedge clk);
    chk("lat_t1_mn", mn[0], 1'b0);
    @(negedge clk);
    chk("lat_t2_mn", mn[0], 1'b1);
    chk("lat_t2_mo", mo[0], 32'h55);
    chk("lat_t2_mc", mc[0], 2);
    @(negedge clk);
    chk("lat_t3_mn", mn[0], 1'b0);
    chk("lat_t3_mo", mo[0], 32'h55);
    idle(12);

    n0 = lane[1].outs.size();
    send(1, 1, 32'd10);
    send(1, 1, 32'd20);
    send(1, 1, 32'hFFFF_FFF0);
    idle(20);
    chk("sum_count", lane[1].outs.size() - n0, 3);
    if (lane[1].outs.size() >= n0 + 3) begin
      chk("sum_0", lane[1].outs[n0], 32'd10);
      chk("sum_1", lane[1].outs[n0+1], 32'd30);
      chk("sum_2", lane[1].outs[n0+2], 32'hE);
    end

    win = 4'b1110;
    sync = '1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      upd = sync & nt[2];
      @(posedge clk);
      #1;
      for (int c = 0; c < NCH; c++)
        if (upd[c]) b_in[c*DW +: DW] = $urandom | 1;
    end
    chk("gap_pulses", lane[2].np >= 8, 1'b1);
    chk("depth2_pulses", lane[3].np >= 8, 1'b1);
    sync = '0;
    win = '0;
    idle(40);

    sync = '1;
    idle(8);
    @(posedge clk);
    #3;
    rst = 1'b0;
    sync = '0;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("mid_rst_notify", nt[i], 4'b0001);
      chk("mid_rst_mn", mn[i], 1'b0);
      chk("mid_rst_mo", mo[i], 0);
      chk("mid_rst_mc", mc[i], 0);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("in_rst_mn", mn[1], 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(2);
    send(1, 3, 32'h1234);
    idle(12);
    chk("post_rst_count", lane[1].outs.size(), 1);
    if (lane[1].outs.size() > 0)
      chk("post_rst_sum", lane[1].outs[0], 32'h1234);

    idle(20);
    chk("drain_0", lane[0].pend, 0);
    chk("drain_1", lane[1].pend, 0);
    chk("drain_2", lane[2].pend, 0);
    chk("drain_3", lane[3].pend, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
